// File: rtl/px_seq_pkg.sv
// rtl/px_seq_pkg.sv - shared types, widths and helpers for the P-X sequencer
// Contents: fsm_t phase enum, TICK_W / ALARM_W counter widths, onehot() builder.
package px_seq_pkg;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_S1,
        FSM_STEP,
        FSM_BREQ,
        FSM_S2,
        FSM_GOT,
        FSM_HALT
    } fsm_t;

    // Phase widths are 1..15 clocks, bus wait is 1..65535 clocks.
    localparam int TICK_W  = $clog2(15) + 1;
    localparam int ALARM_W = $clog2(65535) + 1;

    function automatic logic [63:0] onehot(input int idx);
        onehot = 64'd1 << idx;
    endfunction

endpackage

// File: rtl/px_seq_if.sv
// rtl/px_seq_if.sv - decoder/bus-side signal bundle of the P-X sequencer
// master: the sequencer (drives state, strob1, strob2, got, zg, alarm, awaria, busy;
//         receives enter, start, mode, step_, strob_fp_, zw, ok, en).
// slave : the surrounding decoder, front panel and bus arbiter.
interface px_seq_if #(
    parameter int NSTATES = 20
);
    logic [NSTATES-1:0] enter;
    logic               start;
    logic               mode;
    logic               step_;
    logic               strob_fp_;
    logic               zw;
    logic               ok;
    logic               en;
    logic [NSTATES-1:0] state;
    logic               strob1;
    logic               strob2;
    logic               got;
    logic               zg;
    logic               alarm;
    logic               awaria;
    logic               busy;

    modport master (
        input  enter, start, mode, step_, strob_fp_, zw, ok, en,
        output state, strob1, strob2, got, zg, alarm, awaria, busy
    );

    modport slave (
        output enter, start, mode, step_, strob_fp_, zw, ok, en,
        input  state, strob1, strob2, got, zg, alarm, awaria, busy
    );
endinterface

// File: rtl/px_seq_tick.sv
// rtl/px_seq_tick.sv - loadable down-counter timing one sequencer phase
// Ports: clk, resetn (sync active-low), i_en (phase active), i_len (phase length),
//        o_done (high on the last clock of the phase).
module px_tick #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_en,
    input  logic [W-1:0] i_len,
    output logic         o_done
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    // Zero means "phase not started": the first enabled clock loads the
    // remaining length, later clocks count down, leaving the phase clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_cnt <= i_len - ONE;
        end else begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_done = i_en && ((r_cnt == ONE) || ((r_cnt == '0) && (i_len == ONE)));

endmodule

// File: rtl/px_seq.sv
// rtl/px_seq.sv - P-X state-control sequencer (strob1 / strob2 / got phase generator)
// Ports: __clk, clo_ (sync active-low general clear), bus (px_seq_if.master).
// Option: PX_SEQ_STOP_ON_ALARM_EN - a bus timeout or refusal sends the FSM to HALT.
module px_seq
    import px_seq_pkg::*;
#(
    parameter int                 NSTATES      = 20,
    parameter int                 RESET_STATE  = 0,
    parameter logic [NSTATES-1:0] STROB2_MASK  = '0,
    parameter logic [NSTATES-1:0] BUS_MASK     = '0,
    parameter int                 STROB1_TICKS = 5,
    parameter int                 STROB2_TICKS = 6,
    parameter int                 GOT_TICKS    = 5,
    parameter int                 ALARM_TICKS  = 250
) (
    input  logic     __clk,
    input  logic     clo_,
    px_seq_if.master bus
);
    localparam logic [NSTATES-1:0] RST_VEC = NSTATES'(onehot(RESET_STATE));

    fsm_t               r_fsm;
    fsm_t               w_fsm_next;
    fsm_t               w_exit;
    fsm_t               w_fail_next;
    logic [NSTATES-1:0] r_state;
    logic [NSTATES-1:0] w_got_vec;
    logic               r_run;
    logic               r_awaria;
    logic               r_step_d1;
    logic               r_step_d2;
    logic               r_in_got;
    logic               w_step_fall;
    logic               w_in_breq;
    logic               w_grant_ok;
    logic               w_grant_en;
    logic               w_timeout;
    logic               w_bus_fail;
    logic               w_got_first;
    logic               w_s1_done;
    logic               w_s2_done;
    logic               w_got_done;
    logic               w_wait_done;

    px_tick #(.W(TICK_W)) u_s1_tick (
        .clk(__clk), .resetn(clo_), .i_en(r_run && (r_fsm == FSM_S1)),
        .i_len(TICK_W'(STROB1_TICKS)), .o_done(w_s1_done)
    );
    px_tick #(.W(TICK_W)) u_s2_tick (
        .clk(__clk), .resetn(clo_), .i_en(r_run && (r_fsm == FSM_S2)),
        .i_len(TICK_W'(STROB2_TICKS)), .o_done(w_s2_done)
    );
    px_tick #(.W(TICK_W)) u_got_tick (
        .clk(__clk), .resetn(clo_), .i_en(r_run && (r_fsm == FSM_GOT)),
        .i_len(TICK_W'(GOT_TICKS)), .o_done(w_got_done)
    );
    px_tick #(.W(ALARM_W)) u_wait_tick (
        .clk(__clk), .resetn(clo_), .i_en(w_in_breq),
        .i_len(ALARM_W'(ALARM_TICKS)), .o_done(w_wait_done)
    );

    assign w_step_fall = r_step_d2 && !r_step_d1;
    assign w_in_breq   = r_run && (r_fsm == FSM_BREQ);
    // ok has priority over en when both arrive with the grant.
    assign w_grant_ok  = w_in_breq && bus.zw && bus.ok;
    assign w_grant_en  = w_in_breq && bus.zw && bus.en && !bus.ok;
    assign w_timeout   = w_wait_done && !w_grant_ok && !w_grant_en;
    assign w_bus_fail  = w_grant_en || w_timeout;
    assign w_got_first = r_run && (r_fsm == FSM_GOT) && !r_in_got;
    // With a one-clock got the load and the idle decision share an edge.
    assign w_got_vec   = w_got_first ? bus.enter : r_state;

    assign w_exit = |(r_state & BUS_MASK)    ? FSM_BREQ :
                    |(r_state & STROB2_MASK) ? FSM_S2   : FSM_GOT;

`ifdef PX_SEQ_STOP_ON_ALARM_EN
    assign w_fail_next = FSM_HALT;
`else
    assign w_fail_next = FSM_S2;
`endif

    always_ff @(posedge __clk) begin
        if (!clo_) begin
            r_fsm <= FSM_S1;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // r_run holds the sequencer quiet for the first clock after clear, so
    // the outputs read zero while clo_ is low even though the FSM sits in S1.
    always_comb begin
        w_fsm_next = r_fsm;
        if (r_run) begin
            unique case (r_fsm)
                FSM_IDLE: if (bus.start) w_fsm_next = FSM_S1;
                FSM_S1:   if (w_s1_done) w_fsm_next = bus.mode ? FSM_STEP : w_exit;
                FSM_STEP: if (w_step_fall || !bus.mode) w_fsm_next = w_exit;
                FSM_BREQ: begin
                    if (w_grant_ok)      w_fsm_next = FSM_S2;
                    else if (w_bus_fail) w_fsm_next = w_fail_next;
                end
                FSM_S2:   if (w_s2_done) w_fsm_next = FSM_GOT;
                FSM_GOT:  if (w_got_done) w_fsm_next = (w_got_vec == '0) ? FSM_IDLE : FSM_S1;
                FSM_HALT: w_fsm_next = FSM_HALT;
                default:  w_fsm_next = FSM_S1;
            endcase
        end
    end

    always_comb begin
        bus.strob1 = 1'b0;
        bus.strob2 = 1'b0;
        bus.got    = 1'b0;
        bus.zg     = 1'b0;
        bus.alarm  = 1'b0;
        bus.busy   = 1'b0;
        if (r_run) begin
            bus.strob1 = (r_fsm == FSM_S1) || (!bus.strob_fp_ && (r_fsm != FSM_HALT));
            bus.strob2 = (r_fsm == FSM_S2);
            bus.got    = (r_fsm == FSM_GOT);
            bus.zg     = (r_fsm == FSM_BREQ);
            bus.alarm  = w_timeout;
            bus.busy   = (r_fsm != FSM_IDLE) && (r_fsm != FSM_HALT);
        end
    end

    always_ff @(posedge __clk) begin
        if (!clo_) begin
            r_state   <= RST_VEC;
            r_run     <= 1'b0;
            r_awaria  <= 1'b0;
            r_step_d1 <= 1'b1;
            r_step_d2 <= 1'b1;
            r_in_got  <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            r_step_d1 <= bus.step_;
            r_step_d2 <= r_step_d1;
            r_in_got  <= r_run && (r_fsm == FSM_GOT);
            if (r_run && (r_fsm == FSM_IDLE) && bus.start) begin
                r_state <= RST_VEC;
            end else if (w_got_first) begin
                r_state <= bus.enter;
            end
            if (w_bus_fail) begin
                r_awaria <= 1'b1;
            end
        end
    end

    assign bus.state  = r_state;
    assign bus.awaria = r_awaria;

endmodule

// File: tb/tb_px_seq.sv
// tb/tb_px_seq.sv - self-checking bench for px_seq
module tb_px_seq;
    localparam int          NS      = 20;
    localparam logic [19:0] S2_M    = 20'h00010;
    localparam logic [19:0] BUS_M   = 20'h00004;
    localparam logic [19:0] RST_V   = 20'h00001;
    localparam int          T_S1    = 5;
    localparam int          T_S2    = 6;
    localparam int          T_GOT   = 5;
    localparam int          T_ALARM = 10;

    logic clk  = 1'b0;
    logic clo_ = 1'b0;

    px_seq_if #(.NSTATES(NS)) bus ();

    px_seq #(
        .NSTATES(NS), .RESET_STATE(0), .STROB2_MASK(S2_M), .BUS_MASK(BUS_M),
        .STROB1_TICKS(T_S1), .STROB2_TICKS(T_S2), .GOT_TICKS(T_GOT), .ALARM_TICKS(T_ALARM)
    ) dut (
        .__clk(clk),
        .clo_(clo_),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] m_state;
    bit          m_awaria;
    int          c_s1, c_s2, c_got, c_zg, c_alarm, alarm_at, c_ovl;
    logic [19:0] got_state;
    bit          timed_out;
    int          w_s1, w_rise;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Observes one instruction cycle from the current sample until got ends
    // (or, for a halting cycle, until zg drops), answering the bus as told.
    // kind: 0 none, 1 grant+ok after dly, 2 grant+en after dly, 3 no grant.
    task automatic run_cycle(input logic [19:0] ent, input int kind, input int dly, input bit halt_exp);
        int n = 0;
        bit seen_got = 0;
        bit seen_zg = 0;
        c_s1 = 0; c_s2 = 0; c_got = 0; c_zg = 0; c_alarm = 0; alarm_at = 0; c_ovl = 0;
        got_state = '0;
        timed_out = 0;
        bus.enter = ent;
        bus.zw    = (kind == 1 || kind == 2);
        while (1) begin
            if (seen_got && !bus.got) break;
            if (halt_exp && seen_zg && !bus.zg) break;
            if (n == 200) begin
                timed_out = 1;
                break;
            end
            c_s1  += int'(bus.strob1);
            c_s2  += int'(bus.strob2);
            c_got += int'(bus.got);
            if (int'(bus.strob1) + int'(bus.strob2) + int'(bus.got) > 1) c_ovl++;
            if (bus.zg) begin
                c_zg++;
                seen_zg = 1;
            end
            if (bus.alarm) begin
                c_alarm++;
                alarm_at = c_zg;
            end
            if (bus.got) begin
                seen_got = 1;
                if (c_got == 2) got_state = bus.state;
            end
            if (bus.zg && c_zg == dly && kind == 1) bus.ok = 1'b1;
            if (bus.zg && c_zg == dly && kind == 2) bus.en = 1'b1;
            if (!bus.zg && seen_zg) begin
                bus.ok = 1'b0;
                bus.en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Expected phase lengths come straight from the current state's mask
    // membership; the next state is whatever enter held.
    task automatic do_cycle(input logic [19:0] ent, input int kind, input int dly);
        bit is_bus = |(m_state & BUS_M);
        bit need_s2 = is_bus || |(m_state & S2_M);
        bit halts = 0;
`ifdef PX_SEQ_STOP_ON_ALARM_EN
        halts = is_bus && (kind >= 2);
`endif
        run_cycle(ent, kind, dly, halts);
        check("cycle_done", timed_out, 0);
        check("s1_len", c_s1, T_S1);
        check("zg_len", c_zg, !is_bus ? 0 : (kind == 3 ? T_ALARM : dly));
        check("alarm_cnt", c_alarm, (is_bus && kind == 3) ? 1 : 0);
        if (is_bus && kind == 3) check("alarm_at", alarm_at, T_ALARM);
        if (is_bus && kind >= 2) m_awaria = 1;
        check("awaria", bus.awaria, m_awaria);
        check("no_overlap", c_ovl, 0);
`ifdef PX_SEQ_STOP_ON_ALARM_EN
        if (halts) begin
            check("halt_busy", bus.busy, 0);
            check("halt_strobes", {bus.strob1, bus.strob2, bus.got, bus.zg}, 0);
            repeat (4) @(negedge clk);
            check("halt_state", bus.state, m_state);
            check("halt_busy_late", bus.busy, 0);
            clo_ = 1'b0;
            @(negedge clk);
            check("halt_clr_state", bus.state, RST_V);
            check("halt_clr_awaria", bus.awaria, 0);
            clo_ = 1'b1;
            m_state  = RST_V;
            m_awaria = 0;
        end else
`endif
        begin
            check("s2_len", c_s2, need_s2 ? T_S2 : 0);
            check("got_len", c_got, T_GOT);
            check("got_state", got_state, ent);
            m_state = ent;
        end
    endtask

    task automatic watch(input int n);
        logic prev = 1'b0;
        w_s1 = 0;
        w_rise = 0;
        for (int i = 0; i < n; i++) begin
            w_s1 += int'(bus.strob1);
            if (bus.got && !prev) w_rise++;
            prev = bus.got;
            @(negedge clk);
        end
    endtask

    task automatic wait_until(input int sel, input int budget, input string tag);
        bit hit = 0;
        for (int i = 0; i <= budget; i++) begin
            case (sel)
                0:       hit = bus.got;
                1:       hit = !bus.busy;
                default: hit = bus.strob2;
            endcase
            if (hit) break;
            @(negedge clk);
        end
        check(tag, hit, 1);
    endtask

    initial begin
        logic [19:0] ent;
        int          kind;
        bus.enter = '0; bus.start = 0; bus.mode = 0; bus.step_ = 1;
        bus.strob_fp_ = 1; bus.zw = 0; bus.ok = 0; bus.en = 0;
        repeat (3) @(negedge clk);
        check("rst_state", bus.state, RST_V);
        check("rst_strobes", {bus.strob1, bus.strob2, bus.got}, 0);
        check("rst_zg", bus.zg, 0);
        check("rst_alarm", bus.alarm, 0);
        check("rst_awaria", bus.awaria, 0);
        check("rst_busy", bus.busy, 0);
        clo_ = 1'b1;
        m_state  = RST_V;
        m_awaria = 0;

        do_cycle(20'h00004, 0, 0);
        do_cycle(20'h00010, 1, 3);
        do_cycle(20'h00004, 0, 0);
        do_cycle(20'h00001, 3, 0);

        for (int i = 0; i < 16; i++) begin
            ent = 20'($urandom());
            if (ent == '0) ent = RST_V;
            kind = 0;
            if (|(m_state & BUS_M)) begin
                case ($urandom_range(0, 4))
                    0:       kind = 3;
                    1:       kind = 2;
                    default: kind = 1;
                endcase
`ifdef PX_SEQ_STOP_ON_ALARM_EN
                kind = 1;
`endif
            end
            do_cycle(ent, kind, $urandom_range(1, 8));
        end
        do_cycle(RST_V, (|(m_state & BUS_M)) ? 1 : 0, 2);

        bus.mode  = 1'b1;
        bus.enter = RST_V;
        watch(20);
        check("step_s1", w_s1, T_S1);
        check("step_no_got", w_rise, 0);
        check("step_busy", bus.busy, 1);
        bus.strob_fp_ = 1'b0;
        @(negedge clk);
        check("fp_force", bus.strob1, 1);
        check("fp_no_got", bus.got, 0);
        bus.strob_fp_ = 1'b1;
        @(negedge clk);
        check("fp_release", bus.strob1, 0);

        bus.step_ = 1'b0;
        repeat (2) @(negedge clk);
        bus.step_ = 1'b1;
        watch(40);
        check("step_pulse_got", w_rise, 1);
        check("step_pulse_s1", w_s1, T_S1);
        bus.step_ = 1'b0;
        watch(40);
        check("step_hold_got", w_rise, 1);
        bus.step_ = 1'b1;
        check("step_state", bus.state, RST_V);

        bus.mode = 1'b0;
        wait_until(0, 5, "mode_release");
        bus.enter = '0;
        wait_until(1, 20, "idle_reached");
        check("idle_state", bus.state, 0);
        check("idle_strobes", {bus.strob1, bus.strob2, bus.got, bus.zg}, 0);
        bus.start = 1'b1;
        bus.enter = S2_M;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_state", bus.state, RST_V);
        check("start_strob1", bus.strob1, 1);
        check("start_busy", bus.busy, 1);

        wait_until(2, 40, "reach_strob2");
        repeat (2) @(negedge clk);
        clo_ = 1'b0;
        @(negedge clk);
        check("clr_strobes", {bus.strob1, bus.strob2, bus.got, bus.zg, bus.alarm}, 0);
        check("clr_busy", bus.busy, 0);
        check("clr_state", bus.state, RST_V);
        check("clr_awaria", bus.awaria, 0);
        clo_ = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
